// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle for shift_seq_ctrl.
// master: issue logic / writeback side; slave: the sequencer.
interface shift_seq_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_flag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_flag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_flag
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle 16-bit shift/rotate sequencer. The shift amount is split into
// base-3 digits (weights 1, 3, 9) and applied one digit per clock through a
// single stage shifter.
// Optional: define SHIFT_SEQ_EARLY_EXIT_EN to skip trailing zero-digit stages.
module shift_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_ctrl_if.slave  bus,
  output logic             busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S0   = 3'd1;
  localparam logic [2:0] S1   = 3'd2;
  localparam logic [2:0] S2   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] stage_out;
  logic [DATA_W-1:0] out_data_r;
  logic [2:0]        out_flag_r;
  logic [1:0]        mode;
  logic [1:0]        d0;
  logic [1:0]        d1;
  logic              d2;
  logic [1:0]        dig;
  logic [3:0]        wt;
  logic [4:0]        sh;

  // amt -> {d2, d1, d0}, base-3 digits by table lookup (no divider)
  function automatic logic [4:0] amt_digits(input logic [AMT_W-1:0] amt);
    logic [4:0] r;
    case (amt)
      4'd0:    r = 5'b0_00_00;
      4'd1:    r = 5'b0_00_01;
      4'd2:    r = 5'b0_00_10;
      4'd3:    r = 5'b0_01_00;
      4'd4:    r = 5'b0_01_01;
      4'd5:    r = 5'b0_01_10;
      4'd6:    r = 5'b0_10_00;
      4'd7:    r = 5'b0_10_01;
      4'd8:    r = 5'b0_10_10;
      4'd9:    r = 5'b1_00_00;
      4'd10:   r = 5'b1_00_01;
      4'd11:   r = 5'b1_00_10;
      4'd12:   r = 5'b1_01_00;
      4'd13:   r = 5'b1_01_01;
      4'd14:   r = 5'b1_01_10;
      default: r = 5'b1_10_00;
    endcase
    return r;
  endfunction

  // Select the current digit and its weight, form the stage shift distance
  always_comb begin
    dig = '0;
    wt  = '0;
    sh  = '0;
    case (state)
      S0:      begin dig = d0;         wt = 4'd1; end
      S1:      begin dig = d1;         wt = 4'd3; end
      S2:      begin dig = {1'b0, d2}; wt = 4'd9; end
      default: begin dig = '0;         wt = '0;   end
    endcase
    case (dig)
      2'd1:    sh = {1'b0, wt};
      2'd2:    sh = {wt, 1'b0};
      default: sh = '0;
    endcase
  end

  // Single stage shifter shared by all three digit stages
  always_comb begin
    stage_out = '0;
    case (mode)
      2'b00:   stage_out = acc << sh;
      2'b01:   stage_out = $signed(acc) >>> sh;
      // a zero distance makes the left term shift by DATA_W, i.e. vanish
      2'b10:   stage_out = (acc >> sh) | (acc << (DATA_W - int'(sh)));
      default: stage_out = '0;
    endcase
  end

  // Next-state sequencing IDLE -> S0 -> S1 -> S2 -> DONE -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = S0;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
      S0:   state_nxt = (d1 == 2'd0 && !d2) ? DONE : S1;
      S1:   state_nxt = !d2 ? DONE : S2;
`else
      S0:   state_nxt = S1;
      S1:   state_nxt = S2;
`endif
      S2:   state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accumulator, operand capture and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      mode       <= '0;
      d0         <= '0;
      d1         <= '0;
      d2         <= 1'b0;
      out_data_r <= '0;
      out_flag_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc          <= bus.in_data;
            mode         <= bus.in_mode;
            {d2, d1, d0} <= amt_digits(bus.in_amt);
          end
        end
        S0, S1, S2: begin
          acc <= stage_out;
          // result is latched on the last stage so it holds after DONE
          if (state_nxt == DONE) begin
            out_data_r         <= stage_out;
            out_flag_r         <= '0;
            out_flag_r[FLAG_Z] <= (stage_out == '0);
            out_flag_r[FLAG_V] <= 1'b0;
            out_flag_r[FLAG_N] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_data_r;
  assign bus.out_flag  = out_flag_r;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl; works with or without
// SHIFT_SEQ_EARLY_EXIT_EN defined.
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  shift_seq_ctrl_if #(.DATA_W(16), .AMT_W(4)) bus ();

  shift_seq_ctrl #(.DATA_W(16), .AMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;
  logic [15:0] last_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the full amount directly, one bit at a time
  function automatic logic [15:0] ref_shift(input logic [15:0] data, input int amt,
                                            input logic [1:0] mode);
    logic [15:0] r;
    r = data;
    case (mode)
      2'b00: for (int i = 0; i < amt; i++) r = {r[14:0], 1'b0};
      2'b01: for (int i = 0; i < amt; i++) r = {r[15], r[15:1]};
      2'b10: for (int i = 0; i < amt; i++) r = {r[0], r[15:1]};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Edges from accept (inclusive) until out_valid is seen
  function automatic int exp_lat(input int amt);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    if (amt <= 2) return 2;
    if (amt <= 8) return 3;
    return 4;
`else
    return amt - amt + 4;
`endif
  endfunction

  task automatic start_op(input string tag, input logic [15:0] data, input int amt,
                          input logic [1:0] mode);
    int g;
    int lat;
    logic [15:0] exp;
    exp = ref_shift(data, amt, mode);
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk({tag, " ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_amt   = 4'(amt);
    bus.in_mode  = mode;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.in_amt   = 4'($urandom);
    bus.in_mode  = 2'($urandom);
    chk({tag, " in_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat(amt));
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, " data"}, {16'd0, bus.out_data}, {16'd0, exp});
    chk({tag, " flag"}, {29'd0, bus.out_flag}, {29'd0, 2'b00, exp == 16'h0000});
    last_res = exp;
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, " idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] data, input int amt,
                        input logic [1:0] mode);
    start_op(tag, data, amt, mode);
    finish_op(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    last_res      = '0;

    // reset state
    #12;
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst out_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst out_flag", {29'd0, bus.out_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op("sll_1_15", 16'h0001, 15, 2'b00);
    run_op("sra_8000_15", 16'h8000, 15, 2'b01);
    run_op("sra_4000_14", 16'h4000, 14, 2'b01);
    run_op("ror_1234_4", 16'h1234, 4, 2'b10);
    run_op("ror_abcd_0", 16'hABCD, 0, 2'b10);
    run_op("sll_8000_1", 16'h8000, 1, 2'b00);
    run_op("rsv_5555_7", 16'h5555, 7, 2'b11);
    run_op("sll_amt2", 16'h0003, 2, 2'b00);
    run_op("sll_amt8", 16'h0003, 8, 2'b00);
    run_op("sll_amt9", 16'h0003, 9, 2'b00);

    // backpressure in DONE with in_valid activity
    start_op("bp", 16'hF00F, 5, 2'b10);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 16'($urandom);
      bus.in_amt   = 4'($urandom);
      @(posedge clk); #1;
      chk("bp valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp data", {16'd0, bus.out_data}, {16'd0, last_res});
      chk("bp flag", {29'd0, bus.out_flag}, {29'd0, 2'b00, last_res == 16'h0000});
    end
    bus.in_valid = 1'b0;
    finish_op("bp");
    chk("bp hold_data", {16'd0, bus.out_data}, {16'd0, last_res});
    run_op("bp_next", 16'h00F0, 3, 2'b00);

    // asynchronous reset during S1
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h00FF;
    bus.in_amt   = 4'd9;
    bus.in_mode  = 2'b00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst out_data", {16'd0, bus.out_data}, 32'd0);
    chk("arst out_flag", {29'd0, bus.out_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("arst no_result", {31'd0, bus.out_valid}, 32'd0);
    end
    run_op("arst_fresh", 16'h00FF, 9, 2'b00);

    // randomized sweep of all amounts and modes
    for (int a = 0; a < 16; a++) begin
      for (int m = 0; m < 4; m++) begin
        run_op($sformatf("sweep a%0d m%0d", a, m), 16'($urandom), a, 2'(m));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
